// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave endpoint backed by an internal flop-array memory.
// Read and write channels are independent, with one outstanding burst each.
// FIXED and INCR bursts are always supported. WRAP bursts are supported only when
// the macro AXI_MEM_RESP_WRAP_EN is defined. Without that macro, WRAP requests
// complete with SLVERR and never touch the memory.
// Handshakes are valid/ready. A transfer happens on a rising clk edge where both
// are high. The source holds its payload stable while valid is high and ready is low.
module axi_mem_responder #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 5,
   parameter int MEM_WORDS      = 1024,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]                  aw_len,
   input  logic [2:0]                  aw_size,
   input  logic [1:0]                  aw_burst,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   output logic [1:0]                  b_resp,
   output logic                        b_valid,
   input  logic                        b_ready,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]                  ar_len,
   input  logic [2:0]                  ar_size,
   input  logic [1:0]                  ar_burst,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   output logic [AXI_ID_WIDTH-1:0]     r_id,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   output logic                        r_valid,
   input  logic                        r_ready
);
   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int OFF_BITS = $clog2(STRB_W);
   localparam int IDX_BITS = $clog2(MEM_WORDS);
   localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_WORDS * STRB_W);
   localparam logic [2:0] MAX_SIZE    = 3'(OFF_BITS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_state_d;
   r_state_t r_state, r_state_d;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [AXI_ID_WIDTH-1:0]   w_id_q, r_id_q;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_q, r_addr_q, w_next, r_next, w_off, r_off;
   logic [7:0]                w_len_q, r_len_q, w_cnt_q, r_cnt_q;
   logic [2:0]                w_size_q, r_size_q;
   logic [1:0]                w_burst_q, r_burst_q;
   logic                      w_slv_q, w_dec_q, w_lasterr_q, r_slv_q;
   logic                      aw_err, ar_err, w_hit, r_hit, mem_we;
   logic [IDX_BITS-1:0]       w_idx, r_idx;

   // Request-level checks that make a whole burst SLVERR.
   function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI_MEM_RESP_WRAP_EN
      return (size > MAX_SIZE) || (burst == 2'b11);
`else
      return (size > MAX_SIZE) || (burst == BURST_WRAP) || (burst == 2'b11);
`endif
   endfunction

`ifdef AXI_MEM_RESP_WRAP_EN
   // A WRAP burst needs a length of 2, 4, 8 or 16 beats and a size-aligned start address.
   function automatic logic wrap_err(input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
      logic bad_len, misaligned;
      bad_len    = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      misaligned = (addr & ((AXI_ADDR_WIDTH'(1) << size) - AXI_ADDR_WIDTH'(1))) != '0;
      return (burst == BURST_WRAP) && (bad_len || misaligned);
   endfunction

   // Byte mask of the aligned wrap window: (len+1) * 2^size bytes.
   function automatic logic [AXI_ADDR_WIDTH-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
      return ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
   endfunction
`endif

   // Request legality, range decode and next beat address for both channels.
   always_comb begin
      aw_err = req_err(aw_size, aw_burst);
      ar_err = req_err(ar_size, ar_burst);
`ifdef AXI_MEM_RESP_WRAP_EN
      aw_err = aw_err | wrap_err(aw_addr, aw_len, aw_size, aw_burst);
      ar_err = ar_err | wrap_err(ar_addr, ar_len, ar_size, ar_burst);
`endif
      // The offset wraps below BASE_ADDR, so a single unsigned compare covers both ends.
      w_off = w_addr_q - BASE_ADDR;
      r_off = r_addr_q - BASE_ADDR;
      w_hit = w_off < MEM_BYTES;
      r_hit = r_off < MEM_BYTES;
      w_idx = w_off[OFF_BITS +: IDX_BITS];
      r_idx = r_off[OFF_BITS +: IDX_BITS];
      w_next = (w_burst_q == BURST_FIXED) ? w_addr_q : w_addr_q + (AXI_ADDR_WIDTH'(1) << w_size_q);
      r_next = (r_burst_q == BURST_FIXED) ? r_addr_q : r_addr_q + (AXI_ADDR_WIDTH'(1) << r_size_q);
`ifdef AXI_MEM_RESP_WRAP_EN
      if (w_burst_q == BURST_WRAP)
         w_next = (w_addr_q & ~wrap_mask(w_len_q, w_size_q)) | (w_next & wrap_mask(w_len_q, w_size_q));
      if (r_burst_q == BURST_WRAP)
         r_next = (r_addr_q & ~wrap_mask(r_len_q, r_size_q)) | (r_next & wrap_mask(r_len_q, r_size_q));
`endif
      mem_we = w_valid && w_ready && w_hit && !w_slv_q;
   end

   // FSM state registers; reset aborts any burst in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_d;
         r_state <= r_state_d;
      end
   end

   // Write FSM: next state and channel outputs. Everything is held at zero while rst is high.
   always_comb begin
      w_state_d = w_state;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      b_id      = '0;
      b_resp    = RESP_OKAY;
      if (!rst) begin
         case (w_state)
            W_IDLE: begin
               aw_ready = 1'b1;
               if (aw_valid) w_state_d = W_DATA;
            end
            W_DATA: begin
               w_ready = 1'b1;
               if (w_valid && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
            end
            W_RESP: begin
               b_valid = 1'b1;
               b_id    = w_id_q;
               if (w_slv_q || w_lasterr_q) b_resp = RESP_SLVERR;
               else if (w_dec_q)           b_resp = RESP_DECERR;
               if (b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
         endcase
      end
   end

   // Write burst context: latch the request, then step the address and sticky error flags per beat.
   always_ff @(posedge clk) begin
      if (aw_valid && aw_ready) begin
         w_id_q      <= aw_id;
         w_addr_q    <= aw_addr;
         w_len_q     <= aw_len;
         w_size_q    <= aw_size;
         w_burst_q   <= aw_burst;
         w_cnt_q     <= 8'd0;
         w_slv_q     <= aw_err;
         w_dec_q     <= 1'b0;
         w_lasterr_q <= 1'b0;
      end
      if (w_valid && w_ready) begin
         w_addr_q <= w_next;
         w_cnt_q  <= w_cnt_q + 8'd1;
         if (!w_hit) w_dec_q <= 1'b1;
         if (w_last != (w_cnt_q == w_len_q)) w_lasterr_q <= 1'b1;
      end
   end

   // Byte-enabled memory write; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
         end
      end
   end

   // Read FSM: next state and channel outputs. r_data is combinational, so a write lands one cycle later.
   always_comb begin
      r_state_d = r_state;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      r_id      = '0;
      r_data    = '0;
      r_resp    = RESP_OKAY;
      r_last    = 1'b0;
      if (!rst) begin
         case (r_state)
            R_IDLE: begin
               ar_ready = 1'b1;
               if (ar_valid) r_state_d = R_DATA;
            end
            R_DATA: begin
               r_valid = 1'b1;
               r_id    = r_id_q;
               r_last  = (r_cnt_q == r_len_q);
               if (r_slv_q)     r_resp = RESP_SLVERR;
               else if (!r_hit) r_resp = RESP_DECERR;
               else             r_data = mem[r_idx];
               if (r_ready && r_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
         endcase
      end
   end

   // Read burst context: latch the request, then step the address per accepted beat.
   always_ff @(posedge clk) begin
      if (ar_valid && ar_ready) begin
         r_id_q    <= ar_id;
         r_addr_q  <= ar_addr;
         r_len_q   <= ar_len;
         r_size_q  <= ar_size;
         r_burst_q <= ar_burst;
         r_cnt_q   <= 8'd0;
         r_slv_q   <= ar_err;
      end
      if (r_valid && r_ready) begin
         r_addr_q <= r_next;
         r_cnt_q  <= r_cnt_q + 8'd1;
      end
   end
endmodule
